// File: rtl/blur_line_buffer_if.sv
// Pixel stream in, 3-row column stream out, for blur_line_buffer.
// master: the pixel source / column consumer side; slave: the line buffer.
interface blur_line_buffer_if;
    logic              data_valid_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic [15:0]       pixel_data_in;

    logic              data_valid_out;
    logic [10:0]       hcount_out;
    logic [9:0]        vcount_out;
    logic [2:0][15:0]  data_out;

    modport master (
        output data_valid_in, hcount_in, vcount_in, pixel_data_in,
        input  data_valid_out, hcount_out, vcount_out, data_out
    );

    modport slave (
        input  data_valid_in, hcount_in, vcount_in, pixel_data_in,
        output data_valid_out, hcount_out, vcount_out, data_out
    );
endinterface

// File: rtl/blur_line_buffer.sv
// Four rotating line RAMs feeding a 3x3 blur: one line is written while the
// three previous lines are read at the same column, giving a vertical column
// [0]=row v-1, [1]=row v-2 (centre), [2]=row v-3 two cycles after the accept.
// Optional macro BLUR_LBUF_EDGE_CLAMP_EN replicates the centre row into the
// out-of-frame neighbour on the first and last output rows.
module blur_line_buffer #(
    parameter int HRES = 1280,
    parameter int VRES = 720
) (
    input  logic           clk_in,
    input  logic           rst_in,
    blur_line_buffer_if.slave pix
);

    localparam int AW = $clog2(HRES);

    logic [15:0]    line_ram [4][HRES];
    logic [1:0]     wr_sel;
    logic           accept;
    logic           end_of_line;
    logic [AW-1:0]  addr;
    logic [9:0]     vcount_centre;

    logic           s1_valid;
    logic [10:0]    s1_hcount;
    logic [9:0]     s1_vcount;
    logic [15:0]    rd_below;
    logic [15:0]    rd_centre;
    logic [15:0]    rd_above;
    logic [2:0][15:0] col_next;

    // Reset also blocks accepts so nothing issued during reset reaches the RAMs.
    assign accept = !rst_in && pix.data_valid_in
                    && (pix.hcount_in < 11'(HRES))
                    && (pix.vcount_in < 10'(VRES));
    assign end_of_line   = (pix.hcount_in == 11'(HRES - 1));
    assign addr          = pix.hcount_in[AW-1:0];
    // Centre row lags input by two lines; the first two input rows of a frame
    // drain the last two rows of the previous frame.
    assign vcount_centre = (pix.vcount_in < 10'd2) ? pix.vcount_in + 10'(VRES - 2)
                                                   : pix.vcount_in - 10'd2;

    // RAM write and registered read; select is resolved at issue so rotation
    // on this same edge cannot disturb the beat being read.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            line_ram[wr_sel][addr] <= pix.pixel_data_in;
            rd_below               <= line_ram[wr_sel - 2'd1][addr];
            rd_centre              <= line_ram[wr_sel - 2'd2][addr];
            rd_above               <= line_ram[wr_sel - 2'd3][addr];
        end
    end

    // Write-line rotation, advanced only by an accepted last pixel of a line.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_sel <= 2'd0;
        end else if (accept && end_of_line) begin
            wr_sel <= wr_sel + 2'd1;
        end
    end

    // Read-stage sideband: valid, column and centre row travel with the RAM read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid  <= 1'b0;
            s1_hcount <= '0;
            s1_vcount <= '0;
        end else begin
            s1_valid  <= accept;
            s1_hcount <= pix.hcount_in;
            s1_vcount <= vcount_centre;
        end
    end

    // Column assembly, with optional top/bottom edge replication.
    always_comb begin
        col_next[0] = rd_below;
        col_next[1] = rd_centre;
        col_next[2] = rd_above;
`ifdef BLUR_LBUF_EDGE_CLAMP_EN
        if (s1_vcount == 10'd0) begin
            col_next[2] = rd_centre;
        end
        if (s1_vcount == 10'(VRES - 1)) begin
            col_next[0] = rd_centre;
        end
`else
        // Raw rows: edge columns include lines from the neighbouring frame.
`endif
    end

    // Output register stage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pix.data_valid_out <= 1'b0;
            pix.hcount_out     <= '0;
            pix.vcount_out     <= '0;
            pix.data_out       <= '0;
        end else begin
            pix.data_valid_out <= s1_valid;
            pix.hcount_out     <= s1_hcount;
            pix.vcount_out     <= s1_vcount;
            pix.data_out       <= col_next;
        end
    end

endmodule

// File: tb/tb_blur_line_buffer.sv
// Scoreboard bench for blur_line_buffer with a small frame (8x6). The driver
// predicts each accepted beat from a line-history model and queues it; an
// independent monitor pops and compares whenever data_valid_out is seen.
module tb_blur_line_buffer;

    localparam int HRES = 8;
    localparam int VRES = 6;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   cyc    = 0;

    blur_line_buffer_if bus ();

    blur_line_buffer #(.HRES(HRES), .VRES(VRES)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .pix    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        int               h;
        int               v;
        logic [2:0][15:0] d;
        bit   [2:0]       k;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Line-level reference: four line stores, line index advanced by each
    // completed line; known flags mark entries written since time zero.
    logic [15:0] m_line  [4][HRES];
    bit          m_known [4][HRES];
    int          m_wr    = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input bit vld, input int h, input int v, input logic [15:0] px);
        exp_t e;
        int   s;
        @(posedge clk_in);
        #1;
        bus.data_valid_in = vld;
        bus.hcount_in     = 11'(h);
        bus.vcount_in     = 10'(v);
        bus.pixel_data_in = px;
        if (vld && h < HRES && v < VRES) begin
            e.cyc = cyc + 2;
            e.h   = h;
            e.v   = (v >= 2) ? v - 2 : v + VRES - 2;
            for (int j = 0; j < 3; j++) begin
                s      = (m_wr + 3 - j) % 4;
                e.d[j] = m_line[s][h];
                e.k[j] = m_known[s][h];
            end
`ifdef BLUR_LBUF_EDGE_CLAMP_EN
            if (e.v == 0) begin
                e.d[2] = e.d[1];
                e.k[2] = e.k[1];
            end
            if (e.v == VRES - 1) begin
                e.d[0] = e.d[1];
                e.k[0] = e.k[1];
            end
`endif
            q.push_back(e);
            m_line[m_wr][h]  = px;
            m_known[m_wr][h] = 1'b1;
            if (h == HRES - 1) m_wr = (m_wr + 1) % 4;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk_in);
        #1;
        rst_in            = 1'b1;
        bus.data_valid_in = 1'b1;
        bus.hcount_in     = 11'd2;
        bus.vcount_in     = 10'd3;
        bus.pixel_data_in = 16'($urandom);
        // Beats whose output would land after reset takes effect are aborted.
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        m_wr = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            bus.pixel_data_in = 16'($urandom);
            chk("rst_valid",  48'(bus.data_valid_out), 48'd0);
            chk("rst_hcount", 48'(bus.hcount_out),     48'd0);
            chk("rst_vcount", 48'(bus.vcount_out),     48'd0);
            chk("rst_data",   48'(bus.data_out),       48'd0);
        end
        rst_in            = 1'b0;
        bus.data_valid_in = 1'b0;
    endtask

    task automatic run_frame(input bit rnd_px, input bit gaps, input bit oor, input bit shorts);
        int last_h;
        logic [15:0] px;
        for (int v = 0; v < VRES; v++) begin
            last_h = (shorts && $urandom_range(0, 3) == 0) ? HRES - 2 : HRES - 1;
            for (int h = 0; h <= last_h; h++) begin
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0)
                        drive(1'b0, $urandom_range(0, HRES - 1), v, 16'($urandom));
                end
                if (oor && $urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        drive(1'b1, HRES + $urandom_range(0, 7), v, 16'($urandom));
                    else
                        drive(1'b1, h, VRES + $urandom_range(0, 20), 16'($urandom));
                end
                px = rnd_px ? 16'($urandom) : 16'((v << 8) | h);
                drive(1'b1, h, v, px);
            end
        end
    endtask

    // Monitor: every presented output beat must match the oldest prediction.
    always @(negedge clk_in) begin
        exp_t e;
        if (bus.data_valid_out) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 48'(bus.data_valid_out), 48'd0);
            end else begin
                e = q.pop_front();
                chk("latency",    48'(cyc),            48'(e.cyc));
                chk("hcount_out", 48'(bus.hcount_out), 48'(e.h));
                chk("vcount_out", 48'(bus.vcount_out), 48'(e.v));
                for (int j = 0; j < 3; j++)
                    if (e.k[j]) chk($sformatf("data_out%0d", j), 48'(bus.data_out[j]), 48'(e.d[j]));
            end
        end
    end

    initial begin
        for (int s = 0; s < 4; s++)
            for (int h = 0; h < HRES; h++) begin
                m_line[s][h]  = 16'h0;
                m_known[s][h] = 1'b0;
            end
        bus.data_valid_in = 1'b0;
        bus.hcount_in     = '0;
        bus.vcount_in     = '0;
        bus.pixel_data_in = '0;

        do_reset(3);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);   // plain fill, pattern (v<<8)|h
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);   // same pattern with idle gaps
        run_frame(1'b1, 1'b1, 1'b1, 1'b0);   // random pixels, out-of-range beats
        run_frame(1'b1, 1'b1, 1'b1, 1'b1);   // plus short lines
        for (int h = 0; h < 5; h++) drive(1'b1, h, 2, 16'($urandom));
        do_reset(3);                         // reset mid-line with beats in flight
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 16'h0);
        repeat (6) @(posedge clk_in);
        #1;
        chk("queue_empty", 48'(q.size()), 48'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
